// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard controller for the 5-stage pipeline. It produces 2-bit operand
//   forwarding selects (EX/MEM has priority over MEM/WB). It also generates
//   load-use stalls of LOAD_STALL_CYCLES bubbles, and flushes younger stages
//   on a taken branch/jump.
//
//   Optional build macro: HAZARD_PERF_CNT_EN adds saturating performance
//   counters (stall_cycles_o, flush_events_o, fwd_events_o).
//
// Parameters
//   REG_ADDR_W         register-file address width
//   LOAD_STALL_CYCLES  bubbles per load-use hazard, legal 1..4
//   FLUSH_DEPTH        stages killed on redirect: 1=IF/ID, 2=+ID/EX, 3=+EX/MEM
//   CNT_W              perf counter width (HAZARD_PERF_CNT_EN only)
//
// Ports
//   clk_i, arst_i           clock, async active-high reset
//   enable_i                0 freezes FSM and counters
//   id_rs_i, id_rt_i        ID sources; id_uses_rt_i qualifies rt
//   ex_rs_i, ex_rt_i        EX sources; ex_rd_i / ex_mem_read_i describe a load
//   mem_rd_i, mem_reg_write_i  EX/MEM destination
//   wb_rd_i, wb_reg_write_i    MEM/WB destination
//   redirect_i              taken branch/jump resolved this cycle
//   forward_a_o/_b_o        00 regfile, 01 MEM/WB, 10 EX/MEM
//   pc_en_o, if_id_en_o     front-end enables
//   id_ex_bubble_o          insert NOP controls into ID/EX
//   flush_if_id_o, flush_id_ex_o, flush_ex_mem_o  stage clears
//   stall_active_o          stall asserted this cycle
//
// FSM states
//   state | meaning
//   RUN   | normal issue; single-cycle stall on load-use, flush on redirect
//   STALL | inserting remaining load-use bubbles, cnt_q counts down to 1

module hazard_ctrl_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_DEPTH       = 3,
    parameter int CNT_W             = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  enable_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_reg_write_i,
    input  logic                  redirect_i,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  id_ex_bubble_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic                  flush_ex_mem_o,
    output logic                  stall_active_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_events_o,
    output logic [CNT_W-1:0]      fwd_events_o
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1
    } state_t;

    // The first bubble is issued from RUN, so STALL only covers the rest.
    localparam logic [2:0] CNT_INIT   = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic       KILL_ID_EX = (FLUSH_DEPTH >= 2);
    localparam logic       KILL_EX_MEM = (FLUSH_DEPTH == 3);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
        fwd_b = fwd_sel(ex_rt_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
    end

    assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    flush = 1'b1;
                end else if (load_use) begin
                    stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        cnt_d   = CNT_INIT;
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (redirect_i) begin
                    // The redirected path makes the pending bubbles pointless.
                    flush   = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else if (enable_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced idle while reset is held, independent of the clock.
    always_comb begin
        forward_a_o    = arst_i ? 2'b00 : fwd_a;
        forward_b_o    = arst_i ? 2'b00 : fwd_b;
        pc_en_o        = arst_i | ~stall;
        if_id_en_o     = arst_i | ~stall;
        id_ex_bubble_o = ~arst_i & stall;
        stall_active_o = ~arst_i & stall;
        flush_if_id_o  = ~arst_i & flush;
        flush_id_ex_o  = ~arst_i & flush & KILL_ID_EX;
        flush_ex_mem_o = ~arst_i & flush & KILL_EX_MEM;
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (redirect_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
        if (((fwd_a != 2'b00) || (fwd_b != 2'b00)) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (enable_i) begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
    assign fwd_events_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit. Three instances with different
// stall lengths / flush depths share one randomized stimulus stream; a
// reference model (remaining-bubble count per instance) pushes expected
// outputs into a queue and an independent monitor pops and compares.

module tb_hazard_ctrl_unit;

    localparam int NI = 3;

    function automatic int lsc_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 4;
    endfunction

    function automatic int fd_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 2;
    endfunction

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rt;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rd;
        logic       ex_mr;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       redirect;
    } stim_t;

    // obs bits: [10:9] fwd_a [8:7] fwd_b [6] pc_en [5] if_id_en [4] bubble
    //           [3] flush_if_id [2] flush_id_ex [1] flush_ex_mem [0] stall_active
    typedef struct packed {
        logic [NI-1:0][10:0] obs;
        logic [NI-1:0][3:0]  sc;
        logic [NI-1:0][3:0]  fe;
        logic [NI-1:0][3:0]  fw;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst;
    logic       en;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       uses_rt, ex_mr, mem_we, wb_we, redirect;

    logic [1:0] fa [NI];
    logic [1:0] fb [NI];
    logic       pc [NI];
    logic       ifid [NI];
    logic       bub_o [NI];
    logic       f1 [NI];
    logic       f2 [NI];
    logic       f3 [NI];
    logic       st [NI];
    logic [3:0] sc_o [NI];
    logic [3:0] fe_o [NI];
    logic [3:0] fw_o [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        hazard_ctrl_unit #(
            .REG_ADDR_W       (5),
            .LOAD_STALL_CYCLES((g == 0) ? 3 : (g == 1) ? 1 : 4),
            .FLUSH_DEPTH      ((g == 0) ? 3 : (g == 1) ? 1 : 2),
            .CNT_W            (4)
        ) u_dut (
            .clk_i          (clk),
            .arst_i         (arst),
            .enable_i       (en),
            .id_rs_i        (id_rs),
            .id_rt_i        (id_rt),
            .id_uses_rt_i   (uses_rt),
            .ex_rs_i        (ex_rs),
            .ex_rt_i        (ex_rt),
            .ex_rd_i        (ex_rd),
            .ex_mem_read_i  (ex_mr),
            .mem_rd_i       (mem_rd),
            .mem_reg_write_i(mem_we),
            .wb_rd_i        (wb_rd),
            .wb_reg_write_i (wb_we),
            .redirect_i     (redirect),
            .forward_a_o    (fa[g]),
            .forward_b_o    (fb[g]),
            .pc_en_o        (pc[g]),
            .if_id_en_o     (ifid[g]),
            .id_ex_bubble_o (bub_o[g]),
            .flush_if_id_o  (f1[g]),
            .flush_id_ex_o  (f2[g]),
            .flush_ex_mem_o (f3[g]),
            .stall_active_o (st[g])
`ifdef HAZARD_PERF_CNT_EN
            ,
            .stall_cycles_o (sc_o[g]),
            .flush_events_o (fe_o[g]),
            .fwd_events_o   (fw_o[g])
`endif
        );
`ifndef HAZARD_PERF_CNT_EN
        assign sc_o[g] = 4'h0;
        assign fe_o[g] = 4'h0;
        assign fw_o[g] = 4'h0;
`endif
    end

    // ---------------- reference model ----------------
    int   bub_left [NI];
    int   m_sc [NI];
    int   m_fe [NI];
    int   m_fw [NI];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input stim_t s);
        if (s.mem_we && s.mem_rd != 0 && s.mem_rd == src) return 2'b10;
        if (s.wb_we && s.wb_rd != 0 && s.wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_load_use(input stim_t s);
        return s.ex_mr && s.ex_rd != 0 &&
               (s.ex_rd == s.id_rs || (s.uses_rt && s.ex_rd == s.id_rt));
    endfunction

    function automatic logic [10:0] m_obs(input int i, input stim_t s, input logic rst, input int left);
        logic stall;
        if (rst) return 11'b00_00_1_1_0_0_0_0_0;
        stall = !s.redirect && (left > 0 || m_load_use(s));
        return {m_fwd(s.ex_rs, s), m_fwd(s.ex_rt, s), !stall, !stall, stall,
                s.redirect, s.redirect && fd_of(i) >= 2, s.redirect && fd_of(i) == 3, stall};
    endfunction

    function automatic int sat_inc(input int v, input logic cond);
        return (cond && v < 15) ? v + 1 : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            bub_left[i] = 0;
            m_sc[i] = 0;
            m_fe[i] = 0;
            m_fw[i] = 0;
        end
    endtask

    task automatic model_edge(input stim_t s);
        logic [10:0] o;
        if (arst) begin
            model_clear();
        end else if (s.en) begin
            for (int i = 0; i < NI; i++) begin
                o = m_obs(i, s, 1'b0, bub_left[i]);
                m_sc[i] = sat_inc(m_sc[i], o[0]);
                m_fe[i] = sat_inc(m_fe[i], s.redirect);
                m_fw[i] = sat_inc(m_fw[i], o[10:7] != 4'b0000);
                if (s.redirect)          bub_left[i] = 0;
                else if (bub_left[i] > 0) bub_left[i] = bub_left[i] - 1;
                else if (m_load_use(s))  bub_left[i] = lsc_of(i) - 1;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input stim_t s, input bit pulse);
        exp_t e;
        @(negedge clk);
        arst     = s.rst | pulse;
        en       = s.en;
        id_rs    = s.id_rs;
        id_rt    = s.id_rt;
        uses_rt  = s.uses_rt;
        ex_rs    = s.ex_rs;
        ex_rt    = s.ex_rt;
        ex_rd    = s.ex_rd;
        ex_mr    = s.ex_mr;
        mem_rd   = s.mem_rd;
        mem_we   = s.mem_we;
        wb_rd    = s.wb_rd;
        wb_we    = s.wb_we;
        redirect = s.redirect;
        if (arst) model_clear();
        for (int i = 0; i < NI; i++) begin
            e.obs[i] = m_obs(i, s, arst, bub_left[i]);
            e.sc[i]  = 4'(m_sc[i]);
            e.fe[i]  = 4'(m_fe[i]);
            e.fw[i]  = 4'(m_fw[i]);
        end
        exp_q.push_back(e);
        if (pulse) begin
            #3;
            arst = 1'b0;
        end
        @(posedge clk);
        model_edge(s);
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.en = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst      = ($urandom_range(0, 199) == 0);
        s.en       = ($urandom_range(0, 9) != 0);
        s.id_rs    = 5'($urandom_range(0, 7));
        s.id_rt    = 5'($urandom_range(0, 7));
        s.uses_rt  = 1'($urandom_range(0, 1));
        s.ex_rs    = 5'($urandom_range(0, 7));
        s.ex_rt    = 5'($urandom_range(0, 7));
        s.ex_rd    = 5'($urandom_range(0, 7));
        s.ex_mr    = ($urandom_range(0, 2) == 0);
        s.mem_rd   = 5'($urandom_range(0, 7));
        s.mem_we   = 1'($urandom_range(0, 1));
        s.wb_rd    = 5'($urandom_range(0, 7));
        s.wb_we    = 1'($urandom_range(0, 1));
        s.redirect = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // ---------------- monitor ----------------
    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s inst%0d actual=%h required=%h at %0t", name, i, act, req, $time);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [10:0] o;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NI; i++) begin
                    o = {fa[i], fb[i], pc[i], ifid[i], bub_o[i], f1[i], f2[i], f3[i], st[i]};
                    check("outputs", i, 32'(o), 32'(e.obs[i]));
`ifdef HAZARD_PERF_CNT_EN
                    check("stall_cycles", i, 32'(sc_o[i]), 32'(e.sc[i]));
                    check("flush_events", i, 32'(fe_o[i]), 32'(e.fe[i]));
                    check("fwd_events", i, 32'(fw_o[i]), 32'(e.fw[i]));
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        stim_t s;
        stim_t lu;
        arst = 1'b1;
        en = 1'b1;
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
        {uses_rt, ex_mr, mem_we, wb_we, redirect} = '0;
        model_clear();

        s = idle_stim();
        s.rst = 1'b1;
        step(s, 1'b0);
        step(s, 1'b0);

        // forwarding priority
        s = idle_stim();
        s.mem_rd = 5; s.wb_rd = 5; s.ex_rs = 5; s.mem_we = 1; s.wb_we = 1;
        step(s, 1'b0);
        s.mem_we = 0;
        step(s, 1'b0);
        s.ex_rs = 0;
        step(s, 1'b0);

        lu = idle_stim();
        lu.ex_mr = 1; lu.ex_rd = 8; lu.id_rs = 8;

        // load-use, then let every instance drain
        step(lu, 1'b0);
        repeat (5) step(idle_stim(), 1'b0);

        // redirect during the second stall cycle
        step(lu, 1'b0);
        step(idle_stim(), 1'b0);
        s = idle_stim();
        s.redirect = 1;
        step(s, 1'b0);
        repeat (2) step(idle_stim(), 1'b0);

        // redirect alone, also with a coincident load-use
        step(s, 1'b0);
        s = lu;
        s.redirect = 1;
        step(s, 1'b0);
        step(idle_stim(), 1'b0);

        // async reset pulse mid-stall
        step(lu, 1'b0);
        step(idle_stim(), 1'b1);
        repeat (2) step(idle_stim(), 1'b0);

        // enable low freezes an in-progress stall
        step(lu, 1'b0);
        s = idle_stim();
        s.en = 0;
        repeat (3) step(s, 1'b0);
        repeat (5) step(idle_stim(), 1'b0);

        // long load-use run drives the stall counter to saturation
        repeat (20) step(lu, 1'b0);
        repeat (5) step(idle_stim(), 1'b0);

        for (int n = 0; n < 3000; n++) begin
            s = rand_stim();
            step(s, !s.rst && ($urandom_range(0, 149) == 0));
        end

        repeat (2) @(posedge clk);
        check("queue_drain", 0, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
